// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdp_pkg
// Description : Shared timing defaults, bus widths and helpers for the VDP2.
// Revision    : 1.0 - initial release
// ============================================================================
package vdp_pkg;

    // 1024x768 timing on an 806-line frame
    localparam int c_H_VISIBLE = 1024;
    localparam int c_H_FRONT   = 24;
    localparam int c_H_SYNC    = 136;
    localparam int c_H_TOTAL   = 1344;
    localparam int c_V_VISIBLE = 768;
    localparam int c_V_FRONT   = 3;
    localparam int c_V_SYNC    = 6;
    localparam int c_V_TOTAL   = 806;

    localparam int c_MAP_W       = 9;
    localparam int c_NAME_ADDR_W = 12;
    localparam int c_PAT_ADDR_W  = 11;
    localparam int c_PAL_ADDR_W  = 6;
    localparam int c_COLOR_W     = 12;

    // Per-dot sideband that travels alongside the fetch pipeline
    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic fs;
    } vdp_side_t;

    function automatic logic sync_level(input int pos, input int start,
                                        input int width, input logic pol);
        return ((pos >= start) && (pos < start + width)) ? pol : ~pol;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_palette.sv
`default_nettype none
// ============================================================================
// Module      : vdp_palette
// Description : Colour lookup RAM, one write port, one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_palette
    import vdp_pkg::*;
#(
    parameter int ADDR_W = c_PAL_ADDR_W,
    parameter int DATA_W = c_COLOR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem_q [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata_q;

    // Read-before-write: a same-cycle read of the written entry sees old data
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
        r_rdata_q <= r_mem_q[i_raddr];
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/vdp2.sv
`default_nettype none
// ============================================================================
// Module      : vdp2
// Description : Tile-map video generator: raster timing, 4-stage fetch
//               pipeline, scroll, pixel replication and palette lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp2
    import vdp_pkg::*;
#(
    parameter int   H_VISIBLE  = c_H_VISIBLE,
    parameter int   H_FRONT    = c_H_FRONT,
    parameter int   H_SYNC     = c_H_SYNC,
    parameter int   H_TOTAL    = c_H_TOTAL,
    parameter int   V_VISIBLE  = c_V_VISIBLE,
    parameter int   V_FRONT    = c_V_FRONT,
    parameter int   V_SYNC     = c_V_SYNC,
    parameter int   V_TOTAL    = c_V_TOTAL,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   SCALE_LOG2 = 0
) (
    input  logic                     dot_clk,
    input  logic                     reset,
    input  logic [c_MAP_W-1:0]       scroll_x,
    input  logic [c_MAP_W-1:0]       scroll_y,
    input  logic                     pal_we,
    input  logic [c_PAL_ADDR_W-1:0]  pal_addr,
    input  logic [c_COLOR_W-1:0]     pal_data,
    output logic [c_NAME_ADDR_W-1:0] name_addr,
    input  logic [15:0]              name_data,
    output logic [c_PAT_ADDR_W-1:0]  pattern_addr,
    input  logic [15:0]              pattern_data,
    output logic [3:0]               r,
    output logic [3:0]               g,
    output logic [3:0]               b,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     frame_start
);

    localparam int c_CW = $clog2(H_TOTAL);
    localparam int c_LW = $clog2(V_TOTAL);
    localparam logic [c_CW-1:0] c_H_LAST = c_CW'(H_TOTAL - 1);
    localparam logic [c_LW-1:0] c_V_LAST = c_LW'(V_TOTAL - 1);
    localparam logic [c_CW-1:0] c_H_VIS  = c_CW'(H_VISIBLE);
    localparam logic [c_LW-1:0] c_V_VIS  = c_LW'(V_VISIBLE);
    localparam vdp_side_t c_SIDE_RST = '{vis: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, fs: 1'b0};

    logic [c_CW-1:0]         r_col_q,  w_col_d;
    logic [c_LW-1:0]         r_line_q, w_line_d;
    logic [c_MAP_W-1:0]      r_sx_q,   w_sx_d;
    logic [c_MAP_W-1:0]      r_sy_q,   w_sy_d;
    logic                    r_wrap_q, w_wrap_d;
    logic [2:0]              r_mx2_q,  w_mx2_d;
    logic [2:0]              r_my2_q,  w_my2_d;
    logic [2:0]              r_mx3_q,  w_mx3_d;
    logic [3:0]              r_attr3_q, w_attr3_d;
    vdp_side_t               r_side2_q, w_side2_d;
    vdp_side_t               r_side3_q, w_side3_d;
    vdp_side_t               r_side4_q, w_side4_d;
    logic [c_COLOR_W-1:0]    r_rgb_q,  w_rgb_d;
    logic                    r_hs_q,   w_hs_d;
    logic                    r_vs_q,   w_vs_d;
    logic                    r_fs_q,   w_fs_d;

    logic                    w_col_wrap;
    logic                    w_frame_wrap;
    logic [c_MAP_W-1:0]      w_mx;
    logic [c_MAP_W-1:0]      w_my;
    vdp_side_t               w_side1;
    logic [1:0]              w_pix;
    logic [c_PAL_ADDR_W-1:0] w_pal_raddr;
    logic [c_COLOR_W-1:0]    w_pal_rdata;
    logic                    w_unused;

    always_comb begin
        w_col_wrap   = (r_col_q == c_H_LAST);
        w_frame_wrap = w_col_wrap && (r_line_q == c_V_LAST);
        w_col_d      = w_col_wrap ? '0 : r_col_q + c_CW'(1);
        w_line_d     = r_line_q;
        if (w_col_wrap) begin
            w_line_d = (r_line_q == c_V_LAST) ? '0 : r_line_q + c_LW'(1);
        end
        // Scroll is sampled only on the last dot so a frame never tears
        w_sx_d   = w_frame_wrap ? scroll_x : r_sx_q;
        w_sy_d   = w_frame_wrap ? scroll_y : r_sy_q;
        w_wrap_d = w_frame_wrap;

        w_mx = c_MAP_W'(r_col_q >> SCALE_LOG2) + r_sx_q;
        w_my = c_MAP_W'(r_line_q >> SCALE_LOG2) + r_sy_q;

        w_side1.vis = (r_col_q < c_H_VIS) && (r_line_q < c_V_VIS);
        w_side1.hs  = sync_level(int'(r_col_q), H_VISIBLE + H_FRONT, H_SYNC, SYNC_POL);
        w_side1.vs  = sync_level(int'(r_line_q), V_VISIBLE + V_FRONT, V_SYNC, SYNC_POL);
        // Pulse only for a (0,0) reached by wrapping, not the one after reset
        w_side1.fs  = r_wrap_q;

        w_mx2_d   = w_mx[2:0];
        w_my2_d   = w_my[2:0];
        w_mx3_d   = r_mx2_q;
        w_attr3_d = name_data[3:0];
        w_side2_d = w_side1;
        w_side3_d = r_side2_q;
        w_side4_d = r_side3_q;

        w_rgb_d = r_side4_q.vis ? w_pal_rdata : '0;
        w_hs_d  = r_side4_q.hs;
        w_vs_d  = r_side4_q.vs;
        w_fs_d  = r_side4_q.fs;
    end

    assign name_addr    = {w_my[8:3], w_mx[8:3]};
    assign pattern_addr = {name_data[15:8], r_my2_q};
    assign w_pix        = pattern_data[{r_mx3_q, 1'b0} +: 2];
    assign w_pal_raddr  = {r_attr3_q, w_pix};
    assign w_unused     = &{1'b0, name_data[7:4]};

    vdp_palette #(
        .ADDR_W (c_PAL_ADDR_W),
        .DATA_W (c_COLOR_W)
    ) u_palette (
        .clk     (dot_clk),
        .i_we    (pal_we),
        .i_waddr (pal_addr),
        .i_wdata (pal_data),
        .i_raddr (w_pal_raddr),
        .o_rdata (w_pal_rdata)
    );

    always_ff @(posedge dot_clk or posedge reset) begin
        if (reset) begin
            r_col_q   <= '0;
            r_line_q  <= '0;
            r_sx_q    <= '0;
            r_sy_q    <= '0;
            r_wrap_q  <= 1'b0;
            r_mx2_q   <= '0;
            r_my2_q   <= '0;
            r_mx3_q   <= '0;
            r_attr3_q <= '0;
            r_side2_q <= c_SIDE_RST;
            r_side3_q <= c_SIDE_RST;
            r_side4_q <= c_SIDE_RST;
            r_rgb_q   <= '0;
            r_hs_q    <= ~SYNC_POL;
            r_vs_q    <= ~SYNC_POL;
            r_fs_q    <= 1'b0;
        end else begin
            r_col_q   <= w_col_d;
            r_line_q  <= w_line_d;
            r_sx_q    <= w_sx_d;
            r_sy_q    <= w_sy_d;
            r_wrap_q  <= w_wrap_d;
            r_mx2_q   <= w_mx2_d;
            r_my2_q   <= w_my2_d;
            r_mx3_q   <= w_mx3_d;
            r_attr3_q <= w_attr3_d;
            r_side2_q <= w_side2_d;
            r_side3_q <= w_side3_d;
            r_side4_q <= w_side4_d;
            r_rgb_q   <= w_rgb_d;
            r_hs_q    <= w_hs_d;
            r_vs_q    <= w_vs_d;
            r_fs_q    <= w_fs_d;
        end
    end

    assign r           = r_rgb_q[11:8];
    assign g           = r_rgb_q[7:4];
    assign b           = r_rgb_q[3:0];
    assign hsync       = r_hs_q;
    assign vsync       = r_vs_q;
    assign frame_start = r_fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vdp2.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdp2
// Description : Directed bench for vdp2 on a shrunk 48x24 raster, 1x and 2x.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp2;

    localparam int HT = 48;
    localparam int VT = 24;
    localparam int F  = HT * VT;

    logic        dot_clk;
    logic        reset;
    logic [8:0]  scroll_x, scroll_y;
    logic        pal_we;
    logic [5:0]  pal_addr;
    logic [11:0] pal_data;

    logic [11:0] name_addr, name_addr2;
    logic [15:0] name_data, name_data2;
    logic [10:0] pattern_addr, pattern_addr2;
    logic [15:0] pattern_data, pattern_data2;
    logic [3:0]  r, g, b, r2, g2, b2;
    logic        hsync, vsync, frame_start, hsync2, vsync2, frame_start2;

    logic [15:0] name_mem [4096];
    logic [15:0] pat_mem  [2048];
    logic [11:0] pal_model [64];
    int          sx_arr [16];
    int          sy_arr [16];

    int          n_vec = 0;
    int          n_err = 0;
    int          k = 0;
    logic        pend_v = 1'b0;
    int          pend_cyc = 0;
    logic [5:0]  pend_a = '0;
    logic [11:0] pend_d = '0;

    vdp2 #(.H_VISIBLE(32), .H_FRONT(4), .H_SYNC(8), .H_TOTAL(HT),
           .V_VISIBLE(16), .V_FRONT(2), .V_SYNC(3), .V_TOTAL(VT),
           .SYNC_POL(1'b0), .SCALE_LOG2(0)) dut (
        .dot_clk(dot_clk), .reset(reset), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .name_addr(name_addr), .name_data(name_data),
        .pattern_addr(pattern_addr), .pattern_data(pattern_data),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .frame_start(frame_start));

    vdp2 #(.H_VISIBLE(32), .H_FRONT(4), .H_SYNC(8), .H_TOTAL(HT),
           .V_VISIBLE(16), .V_FRONT(2), .V_SYNC(3), .V_TOTAL(VT),
           .SYNC_POL(1'b0), .SCALE_LOG2(1)) dut2 (
        .dot_clk(dot_clk), .reset(reset), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .name_addr(name_addr2), .name_data(name_data2),
        .pattern_addr(pattern_addr2), .pattern_data(pattern_data2),
        .r(r2), .g(g2), .b(b2), .hsync(hsync2), .vsync(vsync2), .frame_start(frame_start2));

    initial dot_clk = 1'b0;
    always #5 dot_clk = ~dot_clk;

    // External name/pattern memories answer one cycle after the address
    always @(posedge dot_clk) begin
        name_data     <= name_mem[name_addr];
        pattern_data  <= pat_mem[pattern_addr];
        name_data2    <= name_mem[name_addr2];
        pattern_data2 <= pat_mem[pattern_addr2];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (k=%0d): got %0h, expected %0h", tag, k, got, exp);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int col, input int line,
                                              input int sx, input int sy, input int sh);
        logic [8:0]  mx, my;
        logic [15:0] nd, pd;
        logic [1:0]  pix;
        if (col >= 32 || line >= 16) return 12'h000;
        mx  = 9'((col >> sh) + sx);
        my  = 9'((line >> sh) + sy);
        nd  = name_mem[{my[8:3], mx[8:3]}];
        pd  = pat_mem[{nd[15:8], my[2:0]}];
        pix = pd[{mx[2:0], 1'b0} +: 2];
        return pal_model[{nd[3:0], pix}];
    endfunction

    function automatic logic [11:0] model_naddr(input int col, input int line,
                                                input int sx, input int sy, input int sh);
        logic [8:0] mx, my;
        mx = 9'((col >> sh) + sx);
        my = 9'((line >> sh) + sy);
        return {my[8:3], mx[8:3]};
    endfunction

    task automatic check_cycle();
        int          sc, f, col, line;
        logic [11:0] e0, e1, ena;
        logic        ehs, evs, efs;
        e0 = '0; e1 = '0; ena = '0; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
        if (!reset) begin
            if (k % F == F - 1) begin
                sx_arr[k / F + 1] = int'(scroll_x);
                sy_arr[k / F + 1] = int'(scroll_y);
            end
            if (pend_v && (k - 2 > pend_cyc)) begin
                pal_model[pend_a] = pend_d;
                pend_v = 1'b0;
            end
            f   = k / F;
            ena = model_naddr(k % HT, (k / HT) % VT, sx_arr[f], sy_arr[f], 1);
            sc  = k - 4;
            if (sc >= 0) begin
                f    = sc / F;
                col  = sc % HT;
                line = (sc / HT) % VT;
                e0   = model_rgb(col, line, sx_arr[f], sy_arr[f], 0);
                e1   = model_rgb(col, line, sx_arr[f], sy_arr[f], 1);
                ehs  = !(col >= 36 && col <= 43);
                evs  = !(line >= 18 && line <= 20);
                efs  = (sc > 0) && (sc % F == 0);
            end
        end
        check_val("rgb", {r, g, b}, e0);
        check_val("rgb_x2", {r2, g2, b2}, e1);
        check_val("hsync", hsync, ehs);
        check_val("vsync", vsync, evs);
        check_val("frame_start", frame_start, efs);
        check_val("hsync_x2", hsync2, ehs);
        check_val("vsync_x2", vsync2, evs);
        check_val("frame_start_x2", frame_start2, efs);
        check_val("name_addr_x2", name_addr2, ena);
    endtask

    task automatic step();
        @(posedge dot_clk);
        #1;
        k++;
        check_cycle();
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rgb"}, {r, g, b}, 12'h000);
        check_val({tag, "_hsync"}, hsync, 1'b1);
        check_val({tag, "_vsync"}, vsync, 1'b1);
        check_val({tag, "_fs"}, frame_start, 1'b0);
        check_val({tag, "_naddr"}, name_addr, 12'h000);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) name_mem[a] = {8'(a * 3 + 5), 4'h0, 4'(a + 3)};
        for (int a = 0; a < 2048; a++) pat_mem[a] = 16'(a * 40503 + 12345);
        pat_mem[{8'h05, 3'd0}] = 16'h0002;
        for (int i = 0; i < 16; i++) begin sx_arr[i] = 0; sy_arr[i] = 0; end

        reset = 1'b1; scroll_x = '0; scroll_y = '0;
        pal_we = 1'b0; pal_addr = '0; pal_data = '0;

        // Load the palette while held in reset
        for (int i = 0; i < 64; i++) begin
            step();
            pal_we   = 1'b1;
            pal_addr = 6'(i);
            pal_data = (i == 14) ? 12'hF80 : 12'(i * 291 + 7);
            pal_model[i] = pal_data;
        end
        step();
        pal_we = 1'b0;
        check_reset_outputs("reset");

        reset = 1'b0;
        k = 0;
        run_to(2);
        // Overwrite entry 14 in the very cycle pixel (0,0) reads it
        pal_we = 1'b1; pal_addr = 6'd14; pal_data = 12'h00F;
        pend_v = 1'b1; pend_a = 6'd14; pend_d = 12'h00F; pend_cyc = 2;
        step();
        pal_we = 1'b0;
        check_val("latency_pre", {r, g, b}, 12'h000);
        step();
        check_val("latency_rgb", {r, g, b}, 12'hF80);

        run_to(15);
        check_val("x2_naddr_c15", name_addr2, 12'h000);
        step();
        check_val("x2_naddr_c16", name_addr2, 12'h001);

        run_to(F + 4);
        check_val("pal_new", {r, g, b}, 12'h00F);

        run_to(F + 576);
        scroll_x = 9'd9; scroll_y = 9'd3;
        step();
        check_val("scroll_hold", name_addr, 12'h040);

        run_to(2 * F);
        check_val("scroll_naddr", name_addr, 12'h001);
        step();
        check_val("scroll_paddr", pattern_addr, 11'h043);

        run_to(3 * F + 10 * HT + 20);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        for (int i = 0; i < 3; i++) step();
        check_reset_outputs("midreset_end");

        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 16; i++) begin sx_arr[i] = 0; sy_arr[i] = 0; end
        run_to(F + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vdp2.md
VDP2 -- requirements
Module: vdp2

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
  H_VISIBLE, 1024, active pixels per line
  H_FRONT, 24, front porch in dots
  H_SYNC, 136, hsync width in dots
  H_TOTAL, 1344, dots per line
  V_VISIBLE, 768, active lines
  V_FRONT, 3, front porch in lines
  V_SYNC, 6, vsync width in lines
  V_TOTAL, 806, lines per frame
  SYNC_POL, 0, asserted sync level
  SCALE_LOG2, 0, pixel replication; 0 = 1x1, 1 = 2x2
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
  dot_clk  in  1  pixel clock; sole clock
  reset  in  1  asynchronous, active-high reset
  scroll_x  in  9  horizontal scroll in map pixels
  scroll_y  in  9  vertical scroll in map pixels
  pal_we  in  1  palette write strobe
  pal_addr  in  6  palette entry {palette[3:0], index[1:0]}
  pal_data  in  12  palette colour {r, g, b}
  name_addr  out  12  name map address {tile_y[5:0], tile_x[5:0]}
  name_data  in  16  {tile_name[15:8], attributes[7:0]}; valid 1 cycle after name_addr
  pattern_addr  out  11  {tile_name[7:0], row[2:0]}
  pattern_data  in  16  8 pixels x 2 bpp; pixel p at bits [2p+1:2p]; valid 1 cycle after pattern_addr
  r, g, b  out  4 each  registered colour
  hsync, vsync  out  1 each  registered sync
  frame_start  out  1  one-cycle pulse at frame wrap

Function
REQ-003 The column counter SHALL run 0..H_TOTAL-1 and then wrap to 0; the line counter SHALL increment only on column wrap and SHALL wrap from V_TOTAL-1 to 0.
REQ-004 Visible SHALL be (column < H_VISIBLE) and (line < V_VISIBLE).
REQ-005 Raw hsync SHALL equal SYNC_POL for column in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC) and ~SYNC_POL otherwise; raw vsync SHALL be defined the same way on line with the V_* parameters.
REQ-006 Map coordinates SHALL be mx = ((column >> SCALE_LOG2) + sx) mod 512 and my = ((line >> SCALE_LOG2) + sy) mod 512, where sx and sy are the latched scroll values.
REQ-007 name_addr SHALL be {my[8:3], mx[8:3]} and SHALL be driven combinationally from stage-1 registers.
REQ-008 pattern_addr SHALL be {name_data[15:8], my[2:0] delayed by 1 cycle}.
REQ-009 Stage 3 SHALL select the 2-bit pixel using mx[2:0] delayed by 2 cycles; the palette address SHALL be {attributes[3:0] delayed by 1 cycle, pixel}.
REQ-010 The palette SHALL be 64 x 12 bits with a registered read; a write SHALL occur on the dot_clk edge with pal_we high; a read of the address being written in the same cycle SHALL return the old value.
REQ-011 Outputs SHALL appear exactly 4 cycles after the corresponding stage-1 counter state; hsync, vsync and visible SHALL be delayed by the same amount.
REQ-012 r, g and b SHALL be 0 when the delayed visible flag is 0; otherwise they SHALL be the palette entry.
REQ-013 sx and sy SHALL load from scroll_x and scroll_y only when column == H_TOTAL-1 and line == V_TOTAL-1, so scroll changes take effect at frame boundaries only.
REQ-014 frame_start SHALL pulse high for one cycle, aligned with the output pipeline, for pixel (0,0) of each frame.

Reset
REQ-015 While reset is high: column = 0, line = 0, sx = sy = 0, all pipeline visible flags = 0, r = g = b = 0, hsync = vsync = ~SYNC_POL, frame_start = 0.
REQ-016 Palette contents SHALL NOT be reset.
REQ-017 Reset asserted mid-frame SHALL abort the frame; counting SHALL resume at (0,0) on the first edge after deassertion.

Structure
REQ-018 The default timing constants (1024x768 timing and the 806-line frame) and the address field widths SHALL live in a shared package vdp_pkg.
REQ-019 The palette SHALL be a sub-module, vdp_palette, with one write port and one registered read port.

Verification
REQ-020 Timing: defaults, run 2 frames -> hsync low for columns 1048..1183, vsync low for lines 771..776, frame_start period 1344*806 cycles.
REQ-021 Latency: name_data = 0x0503, pattern_data = 0x0002 (pixel 0 = 2), palette[14] = 0xF80 -> at dot (0,0), r/g/b = F/8/0 exactly 4 cycles after column = 0.
REQ-022 Scroll: scroll_x written to 9 mid-frame -> unchanged until the next frame; then name_addr at column 0 = 0x001, and pixel select = 1.
REQ-023 Scale: SCALE_LOG2 = 1 -> name_addr changes every 16 columns; each map pixel is output on 2 consecutive dots and 2 consecutive lines.
REQ-024 Palette collision: write palette[14] = 0x00F in the same cycle it is read -> the old colour is output that cycle, 0x00F thereafter.
REQ-025 Reset: assert at line 400, column 500 for 3 cycles -> r/g/b = 0 and syncs inactive during reset; the first frame_start comes 1344*806 cycles after release.
